// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative HI/LO multiply/divide unit for a MIPS-style pipeline.
//   MULT/MULTU use a 32-cycle shift-add multiplier. DIV/DIVU use a 32-cycle
//   restoring divider. One FIN cycle then applies sign correction and writes
//   HI/LO. MTHI/MTLO write HI/LO directly at the accepting edge.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-high reset
//   start    in   1  request from EX stage (sampled only in IDLE)
//   op       in   3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI,
//                    101 MTLO, 110/111 no-op
//   rs_data  in  32  operand A (multiplicand / dividend / MTHI-MTLO source)
//   rt_data  in  32  operand B (multiplier / divisor)
//   busy     out  1  operation in progress
//   done     out  1  one-cycle pulse after HI/LO written by MUL/DIV
//   hi       out 32  HI register
//   lo       out 32  LO register
// ---------------------------------------------------------------------------
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic [31:0] r_opb;      // multiplicand (MUL) or divisor magnitude (DIV)
    logic [63:0] r_prod;     // upper half accumulates, lower half holds multiplier
    logic [32:0] r_rem;      // partial remainder
    logic [31:0] r_quo;      // dividend shifts out the top, quotient in the bottom
    logic        r_is_div;
    logic        r_neg_res;  // negate product / quotient
    logic        r_neg_rem;  // negate remainder (dividend was negative)
    logic        r_div0;

    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    always_comb begin
        w_signed    = ~op[2] & ~op[0];
        w_abs_a     = (w_signed & rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
        w_abs_b     = (w_signed & rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
        w_mul_sum   = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_opb} : 33'd0);
        w_div_shift = {r_rem[31:0], r_quo[31]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opb});
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_prod_fix  = r_neg_res ? (~r_prod + 64'd1) : r_prod;
        w_quo_fix   = r_neg_res ? (~r_quo + 32'd1) : r_quo;
        w_rem_fix   = r_neg_rem ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_cnt     <= 5'd0;
            r_opb     <= 32'd0;
            r_prod    <= 64'd0;
            r_rem     <= 33'd0;
            r_quo     <= 32'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        case (op)
                            3'b000, 3'b001: begin
                                r_opb     <= w_abs_a;
                                r_prod    <= {32'd0, w_abs_b};
                                r_is_div  <= 1'b0;
                                r_neg_res <= w_signed & (rs_data[31] ^ rt_data[31]);
                                r_neg_rem <= 1'b0;
                                r_div0    <= 1'b0;
                                r_cnt     <= 5'd0;
                                r_busy    <= 1'b1;
                                r_state   <= StMul;
                            end
                            3'b010, 3'b011: begin
                                r_opb     <= w_abs_b;
                                r_quo     <= w_abs_a;
                                r_rem     <= 33'd0;
                                r_is_div  <= 1'b1;
                                r_neg_res <= w_signed & (rs_data[31] ^ rt_data[31]);
                                r_neg_rem <= w_signed & rs_data[31];
                                r_div0    <= (rt_data == 32'd0);
                                r_cnt     <= 5'd0;
                                r_busy    <= 1'b1;
                                r_state   <= StDiv;
                            end
                            3'b100:  r_hi <= rs_data;
                            3'b101:  r_lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    r_prod <= {w_mul_sum, r_prod[31:1]};
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= StFin;
                    end
                end
                StDiv: begin
                    if (w_div_ge) begin
                        r_rem <= w_div_diff;
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_div_shift;
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= StFin;
                    end
                end
                StFin: begin
                    if (r_is_div) begin
                        // Divide by zero: restoring loop leaves remainder = |rs|,
                        // so only the quotient needs forcing.
                        r_hi <= w_rem_fix;
                        r_lo <= r_div0 ? 32'hFFFF_FFFF : w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit. Expected HI/LO pairs are pushed to
//   a scoreboard queue when an op is issued and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp;
    int          n_bad;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        logic [63:0]        p;
        case (o)
            3'b000: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p;
            end
            3'b001: return {32'd0, a} * {32'd0, b};
            3'b010: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest pending result.
    always @(posedge clk) begin
        logic [63:0] e;
        #1;
        if (done) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_hi", {32'd0, hi}, {32'd0, e[63:32]});
                check_val("sb_lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
        end
    end

    // Issue a MUL/DIV op from the current (just-after-edge) point and wait for done.
    // With disturb set, a MTLO request and operand changes are driven while busy.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit disturb);
        int cnt;
        int bcnt;
        sb_q.push_back(exp);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && cnt < 40) begin
            if (disturb && cnt == 5) begin
                start   = 1'b1;
                op      = 3'b101;
                rs_data = 32'hDEAD_BEEF;
                rt_data = 32'h0000_0077;
            end
            if (disturb && cnt == 32) start = 1'b0;
            if (cnt == 16) check_val("hold_hilo", {hi, lo}, {m_hi, m_lo});
            @(posedge clk);
            #1;
            cnt++;
            if (busy) bcnt++;
        end
        check_val("done_latency", cnt, 33);
        check_val("busy_cycles", bcnt, 33);
        check_val("busy_low_on_done", {63'd0, busy}, 64'd0);
        if (!done && sb_q.size() != 0) void'(sb_q.pop_back());
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic move_to(input logic [2:0] o, input logic [31:0] a);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (o == 3'b100) m_hi = a;
        if (o == 3'b101) m_lo = a;
        check_val("mt_hi", {32'd0, hi}, {32'd0, m_hi});
        check_val("mt_lo", {32'd0, lo}, {32'd0, m_lo});
        check_val("mt_busy_done", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  o;
        n_cmp   = 0;
        n_bad   = 0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        rst     = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        rs_data = 32'd0;
        rt_data = 32'd0;
        #1 rst = 1'b1;
        #2;
        check_val("reset_state", {hi, lo}, 64'd0);
        check_val("reset_flags", {62'd0, busy, done}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // First start right after reset release.
        run_op(3'b001, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'hFFFF_FFFE}, 1'b0);
        run_op(3'b000, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1'b0);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_op(3'b011, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF}, 1'b0);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b0);

        @(posedge clk);
        #1;
        move_to(3'b100, 32'h1234_5678);
        move_to(3'b101, 32'h0BAD_F00D);
        move_to(3'b110, 32'h5555_5555);
        move_to(3'b111, 32'hAAAA_AAAA);

        // MTLO presented while busy must be ignored; operand changes too.
        run_op(3'b001, 32'h0001_0003, 32'h0000_0100, {32'd0, 32'h0100_0300}, 1'b1);
        check_val("mtlo_ignored", {32'd0, lo}, {32'd0, 32'h0100_0300});

        // Reset mid-operation aborts with no result.
        start   = 1'b1;
        op      = 3'b001;
        rs_data = 32'd100;
        rt_data = 32'd100;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("abort_hilo", {hi, lo}, 64'd0);
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_op(3'b001, 32'd3, 32'd4, {32'd0, 32'd12}, 1'b0);

        // Overflow divide, then DIVU started on the done cycle.
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
        run_op(3'b011, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);

        for (int i = 0; i < 8; i++) begin
            o = 3'(i % 4);
            a = $urandom;
            b = (i == 5) ? 32'd0 : $urandom >> (i * 3);
            run_op(o, a, b, model(o, a, b), 1'b0);
        end

        repeat (3) @(posedge clk);
        #2;
        check_val("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, on ports clk and rst.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request from EX stage, driven from the ID/EX register outputs.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- rs_data  in  32  operand A (multiplicand or dividend; source for MTHI/MTLO).
- rt_data  in  32  operand B (multiplier or divisor).
- busy  out  1  operation in progress; pipeline stalls EX while high.
- done  out  1  one-cycle pulse, HI/LO just updated by MULT/DIV.
- hi  out  32  HI register.
- lo  out  32  LO register.

Function
REQ-003 The block SHALL implement states IDLE, MUL, DIV, FIN.
REQ-004 start SHALL be accepted only at a rising edge where state is IDLE and start=1; in any other state start is ignored.
REQ-005 MTHI (op 100) accepted at edge N SHALL set hi=rs_data at edge N, with state staying IDLE, busy=0 and no done pulse.
REQ-006 MTLO (op 101) accepted at edge N SHALL set lo=rs_data at edge N, with state staying IDLE, busy=0 and no done pulse.
REQ-007 op 110/111 SHALL have no effect.
REQ-008 On acceptance of MULT, MULTU, DIV or DIVU at edge N, the block SHALL latch operand magnitudes, result-sign flags and op.
- Signed ops take absolute values.
- Unsigned ops take the operands unchanged.
- The block then enters MUL or DIV.
REQ-009 MUL SHALL run exactly 32 cycles of shift-add, one multiplier bit per cycle, into a 64-bit product.
REQ-010 DIV SHALL run exactly 32 cycles of restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
REQ-011 After the 32nd iteration, the block SHALL enter FIN for one cycle and apply sign correction.
- MULT: product negated (64-bit two's complement) if rs[31]^rt[31].
- DIV: quotient negated if rs[31]^rt[31]; remainder negated if rs[31].
REQ-012 hi/lo SHALL be written at edge N+33.
- Multiply: hi=product[63:32], lo=product[31:0].
- Divide: hi=remainder, lo=quotient.
- The state then returns to IDLE.
REQ-013 busy SHALL be 1 from after edge N until edge N+33, and 0 otherwise.
REQ-014 done SHALL be 1 for exactly the cycle after edge N+33.
REQ-015 A new start is accepted at edge N+33+1 at the earliest (back-to-back ops allowed on the done cycle).
REQ-016 Divide by zero (rt_data=0, DIV or DIVU) SHALL complete with normal latency, giving lo=32'hFFFFFFFF and hi=rs_data as originally presented.
REQ-017 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0, with no exception signalled.
REQ-018 Operands SHALL be sampled only at acceptance; changes to rs_data/rt_data/op while busy SHALL NOT affect the result.
REQ-019 hi/lo SHALL hold their values between writes, and SHALL hold their previous values throughout MUL/DIV/FIN.

Reset
REQ-020 While rst=1, asynchronously, the block SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear all internal datapath registers.
REQ-021 A reset asserted mid-operation SHALL abort the operation, with no partial result ever reaching hi/lo.
REQ-022 The first start SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-023 The bench SHALL check: MULTU rs=32'hFFFFFFFF, rt=2 -> busy for 33 cycles, done pulse, hi=1, lo=32'hFFFFFFFE.
REQ-024 The bench SHALL check: MULT rs=-3, rt=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1 at edge N+33.
REQ-025 The bench SHALL check: DIV rs=-7, rt=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU rs=7, rt=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-026 The bench SHALL check: MTHI rs=32'h12345678 -> hi updated same edge, busy stays 0; then MULTU followed by start (MTLO) while busy -> MTLO ignored, lo=product low word.
REQ-027 The bench SHALL check: MULTU 100*100, rst pulsed at cycle 10 -> hi=lo=0, busy=0, no done pulse; a following MULTU 3*4 -> lo=12, hi=0 after 33 cycles.
REQ-028 The bench SHALL check: DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0; back-to-back DIVU started on the done cycle accepted.
